// File: rtl/pwr_mode_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwr_mode_seq : power-mode sequencer (DVS, isolation, retention, power gating)
// Optional idle-driven low-power entry: define PWR_SEQ_AUTO_IDLE_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pwr_mode_seq #(
  parameter int SAVE_CYCLES = 2,
  parameter int WAKE_CYCLES = 8,
  parameter int IDLE_THRESH = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lp_req,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       data_valid,
  output logic       low_power_mode,
  output logic       pg_enable,
  output logic       iso_en,
  output logic       save_en,
  output logic       restore_en,
  output logic       sleep_ack,
  output logic       wake_done,
  output logic [2:0] state_o
);

  localparam logic [2:0] ST_ACTIVE  = 3'd0;
  localparam logic [2:0] ST_LOWPWR  = 3'd1;
  localparam logic [2:0] ST_ISO     = 3'd2;
  localparam logic [2:0] ST_SAVE    = 3'd3;
  localparam logic [2:0] ST_GATED   = 3'd4;
  localparam logic [2:0] ST_PWRUP   = 3'd5;
  localparam logic [2:0] ST_RESTORE = 3'd6;
  localparam logic [2:0] ST_DEISO   = 3'd7;

  localparam int CNT_MAX = (SAVE_CYCLES > WAKE_CYCLES) ? SAVE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SAVE_LOAD = CNT_W'(SAVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             low_power_mode_q, low_power_mode_d;
  logic             pg_enable_q, pg_enable_d;
  logic             iso_en_q, iso_en_d;
  logic             save_en_q, save_en_d;
  logic             restore_en_q, restore_en_d;
  logic             sleep_ack_q, sleep_ack_d;
  logic             wake_done_q, wake_done_d;
  logic             idle_hit;
  logic             lp_exit;

`ifdef PWR_SEQ_AUTO_IDLE_EN
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_THRESH - 1);

  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        auto_lp_q, auto_lp_d;

  assign idle_hit = (state_q == ST_ACTIVE) && !data_valid && (idle_cnt_q == IDLE_LAST);
  // An idle-entered LOWPWR is left only on renewed filter activity.
  assign lp_exit  = auto_lp_q ? data_valid : !lp_req;

  always_comb begin
    idle_cnt_d = '0;
    auto_lp_d  = auto_lp_q;
    if (state_q == ST_ACTIVE && state_d == ST_ACTIVE && !data_valid)
      idle_cnt_d = idle_cnt_q + 16'd1;
    if (state_q == ST_ACTIVE && state_d == ST_LOWPWR)
      auto_lp_d = !lp_req;
    else if (state_d != ST_LOWPWR)
      auto_lp_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
      auto_lp_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      auto_lp_q  <= auto_lp_d;
    end
  end
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = data_valid ^ (IDLE_THRESH == 0);
  assign idle_hit        = 1'b0;
  assign lp_exit         = !lp_req;
`endif

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_ACTIVE;
      cnt_q            <= '0;
      low_power_mode_q <= 1'b0;
      pg_enable_q      <= 1'b0;
      iso_en_q         <= 1'b0;
      save_en_q        <= 1'b0;
      restore_en_q     <= 1'b0;
      sleep_ack_q      <= 1'b0;
      wake_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      low_power_mode_q <= low_power_mode_d;
      pg_enable_q      <= pg_enable_d;
      iso_en_q         <= iso_en_d;
      save_en_q        <= save_en_d;
      restore_en_q     <= restore_en_d;
      sleep_ack_q      <= sleep_ack_d;
      wake_done_q      <= wake_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACTIVE: begin
        if (sleep_req)
          state_d = ST_ISO;
        else if (lp_req || idle_hit)
          state_d = ST_LOWPWR;
      end
      ST_LOWPWR: begin
        if (sleep_req)
          state_d = ST_ISO;
        else if (lp_exit)
          state_d = ST_ACTIVE;
      end
      ST_ISO: begin
        state_d = ST_SAVE;
        cnt_d   = SAVE_LOAD;
      end
      ST_SAVE: begin
        if (cnt_q == '0)
          state_d = ST_GATED;
        else
          cnt_d = cnt_q - 1'b1;
      end
      ST_GATED: begin
        if (wake_req) begin
          state_d = ST_PWRUP;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_PWRUP: begin
        if (cnt_q == '0)
          state_d = ST_RESTORE;
        else
          cnt_d = cnt_q - 1'b1;
      end
      ST_RESTORE: state_d = ST_DEISO;
      ST_DEISO:   state_d = ST_ACTIVE;
      default:    state_d = ST_ACTIVE;
    endcase
  end

  // Outputs are decoded from the next state so each lands in a flop.
  always_comb begin
    low_power_mode_d = (state_d == ST_LOWPWR);
    pg_enable_d      = (state_d == ST_GATED);
    save_en_d        = (state_d == ST_SAVE);
    restore_en_d     = (state_d == ST_RESTORE);
    iso_en_d         = (state_d == ST_ISO)   || (state_d == ST_SAVE) ||
                       (state_d == ST_GATED) || (state_d == ST_PWRUP) ||
                       (state_d == ST_RESTORE);
    sleep_ack_d      = (state_d == ST_GATED) && (state_q != ST_GATED);
    wake_done_d      = (state_d == ST_ACTIVE) && (state_q == ST_DEISO);
  end

  assign low_power_mode = low_power_mode_q;
  assign pg_enable      = pg_enable_q;
  assign iso_en         = iso_en_q;
  assign save_en        = save_en_q;
  assign restore_en     = restore_en_q;
  assign sleep_ack      = sleep_ack_q;
  assign wake_done      = wake_done_q;
  assign state_o        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pwr_mode_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pwr_mode_seq : scoreboard bench for pwr_mode_seq (directed sequences)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_pwr_mode_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lp_req = 1'b0;
  logic       sleep_req = 1'b0;
  logic       wake_req = 1'b0;
  logic       data_valid = 1'b0;
  logic       low_power_mode, pg_enable, iso_en, save_en, restore_en;
  logic       sleep_ack, wake_done;
  logic [2:0] state_o;

  pwr_mode_seq #(
    .SAVE_CYCLES(2),
    .WAKE_CYCLES(8),
    .IDLE_THRESH(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lp_req        (lp_req),
    .sleep_req     (sleep_req),
    .wake_req      (wake_req),
    .data_valid    (data_valid),
    .low_power_mode(low_power_mode),
    .pg_enable     (pg_enable),
    .iso_en        (iso_en),
    .save_en       (save_en),
    .restore_en    (restore_en),
    .sleep_ack     (sleep_ack),
    .wake_done     (wake_done),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  // Expected word: {state, low_power_mode, pg_enable, iso_en, save_en, restore_en, sleep_ack, wake_done}
  typedef struct {
    string      name;
    int         cyc;
    logic [9:0] v;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [9:0] mon_got;
  int         checks = 0;
  int         passed = 0;
  logic [2:0] prev_st = 3'd0;
  int         tcyc = 0;

  // Output table for each state: {lpm, pg, iso, save, restore}
  function automatic logic [4:0] state_outs(input logic [2:0] st);
    case (st)
      3'd1:    return 5'b10000;
      3'd2:    return 5'b00100;
      3'd3:    return 5'b00110;
      3'd4:    return 5'b01100;
      3'd5:    return 5'b00100;
      3'd6:    return 5'b00101;
      default: return 5'b00000;
    endcase
  endfunction

  // One clock cycle: drive inputs and queue the state expected in this cycle.
  task automatic cyc(input string nm, input bit rs, input bit lp, input bit sl,
                     input bit wk, input bit dv, input logic [2:0] st);
    exp_t e;
    logic ack, done;
    @(posedge clk);
    #1;
    reset      = rs;
    lp_req     = lp;
    sleep_req  = sl;
    wake_req   = wk;
    data_valid = dv;
    ack  = (st == 3'd4) && (prev_st != 3'd4) && !rs;
    done = (st == 3'd0) && (prev_st == 3'd7) && !rs;
    e.name = nm;
    e.cyc  = tcyc;
    e.v    = {st, state_outs(st), ack, done};
    sb.push_back(e);
    prev_st = st;
    tcyc++;
  endtask

  task automatic do_reset(input string nm);
    cyc(nm, 1, 0, 0, 0, 0, 3'd0);
    cyc(nm, 1, 0, 0, 0, 0, 3'd0);
    tcyc = 0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_got = {state_o, low_power_mode, pg_enable, iso_en, save_en, restore_en,
                 sleep_ack, wake_done};
      checks++;
      if (mon_got === mon_e.v) passed++;
      else $display("FAIL %s cycle %0d: got %b expected %b", mon_e.name, mon_e.cyc,
                    mon_got, mon_e.v);
      checks++;
      if ($countones({save_en, restore_en, pg_enable}) <= 1) passed++;
      else $display("FAIL excl %s cycle %0d: save/restore/pg got %b expected at most one high",
                    mon_e.name, mon_e.cyc, {save_en, restore_en, pg_enable});
    end
  end

  initial begin
    // Reset abort in the second SAVE cycle
    do_reset("rst");
    cyc("rst_mid_save", 0, 0, 1, 0, 0, 3'd0);
    cyc("rst_mid_save", 0, 0, 0, 0, 0, 3'd2);
    cyc("rst_mid_save", 0, 0, 0, 0, 0, 3'd3);
    cyc("rst_mid_save", 1, 0, 0, 0, 0, 3'd0);
    cyc("rst_mid_save", 1, 0, 0, 0, 0, 3'd0);
    repeat (3) cyc("rst_mid_save", 0, 0, 0, 0, 0, 3'd0);

    // Full sleep/wake with defaults; sleep_req drops right after entry
    do_reset("rst");
    cyc("sleep_wake", 0, 0, 1, 0, 0, 3'd0);
    cyc("sleep_wake", 0, 0, 0, 0, 0, 3'd2);
    repeat (2)  cyc("sleep_wake", 0, 0, 0, 0, 0, 3'd3);
    repeat (16) cyc("sleep_wake", 0, 0, 0, 0, 0, 3'd4);
    cyc("sleep_wake", 0, 0, 0, 1, 0, 3'd4);
    repeat (8)  cyc("sleep_wake", 0, 0, 0, 0, 0, 3'd5);
    cyc("sleep_wake", 0, 0, 0, 0, 0, 3'd6);
    cyc("sleep_wake", 0, 0, 0, 0, 0, 3'd7);
    cyc("sleep_wake", 0, 0, 0, 0, 0, 3'd0);
    cyc("sleep_wake", 0, 0, 0, 0, 0, 3'd0);

    // DVS entry and exit
    do_reset("rst");
    cyc("dvs", 0, 1, 0, 0, 0, 3'd0);
    repeat (9) cyc("dvs", 0, 1, 0, 0, 0, 3'd1);
    cyc("dvs", 0, 0, 0, 0, 0, 3'd1);
    repeat (2) cyc("dvs", 0, 0, 0, 0, 0, 3'd0);

    // Simultaneous lp_req and sleep_req: sleep wins
    do_reset("rst");
    cyc("simul", 0, 1, 1, 0, 0, 3'd0);
    cyc("simul", 0, 1, 0, 0, 0, 3'd2);
    repeat (2) cyc("simul", 0, 1, 0, 0, 0, 3'd3);
    cyc("simul", 0, 0, 0, 1, 0, 3'd4);
    repeat (8) cyc("simul", 0, 0, 0, 0, 0, 3'd5);
    cyc("simul", 0, 0, 0, 0, 0, 3'd6);
    cyc("simul", 0, 0, 0, 0, 0, 3'd7);
    repeat (2) cyc("simul", 0, 0, 0, 0, 0, 3'd0);

    // Early wake held through entry; requests during wake ignored
    do_reset("rst");
    cyc("early_wake", 0, 0, 1, 0, 0, 3'd0);
    cyc("early_wake", 0, 0, 0, 1, 0, 3'd2);
    repeat (2) cyc("early_wake", 0, 0, 0, 1, 0, 3'd3);
    cyc("early_wake", 0, 0, 0, 1, 0, 3'd4);
    repeat (8) cyc("early_wake", 0, 1, 1, 0, 0, 3'd5);
    cyc("early_wake", 0, 0, 0, 0, 0, 3'd6);
    cyc("early_wake", 0, 0, 0, 0, 0, 3'd7);
    repeat (2) cyc("early_wake", 0, 0, 0, 0, 0, 3'd0);

    // Sleep requested from LOWPWR
    do_reset("rst");
    cyc("lp_to_sleep", 0, 1, 0, 0, 0, 3'd0);
    cyc("lp_to_sleep", 0, 1, 1, 0, 0, 3'd1);
    cyc("lp_to_sleep", 0, 0, 0, 0, 0, 3'd2);
    repeat (2) cyc("lp_to_sleep", 0, 0, 0, 0, 0, 3'd3);
    cyc("lp_to_sleep", 0, 0, 0, 1, 0, 3'd4);
    repeat (8) cyc("lp_to_sleep", 0, 0, 0, 0, 0, 3'd5);
    cyc("lp_to_sleep", 0, 0, 0, 0, 0, 3'd6);
    cyc("lp_to_sleep", 0, 0, 0, 0, 0, 3'd7);
    cyc("lp_to_sleep", 0, 0, 0, 0, 0, 3'd0);

`ifdef PWR_SEQ_AUTO_IDLE_EN
    // Idle-driven LOWPWR entry and activity-driven exit
    do_reset("rst");
    repeat (16) cyc("auto_idle", 0, 0, 0, 0, 0, 3'd0);
    repeat (4)  cyc("auto_idle", 0, 0, 0, 0, 0, 3'd1);
    cyc("auto_idle", 0, 0, 0, 0, 1, 3'd1);
    repeat (16) cyc("auto_idle", 0, 0, 0, 0, 0, 3'd0);
    cyc("auto_idle", 0, 0, 0, 0, 1, 3'd1);
    cyc("auto_idle", 0, 0, 0, 0, 0, 3'd0);
`endif

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d queued entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
